// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the ring oscillator measurement controller.
package ring_osc_pkg;

  localparam int DEF_TAP_W = 3;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT
  } state_t;

  // One phase counter serves both settle and window, so it must hold the longer of the two.
  function automatic int phase_cnt_width(input int window_cycles, input int settle_cycles);
    int longest;
    longest = (window_cycles > settle_cycles) ? window_cycles : settle_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous ring output into the clk domain and flags its rising edges.
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic edge_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= osc_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign edge_pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Tap-select / settle / count-window sequencer for the tapped ring oscillator.
// Optional min/max tracking outputs are built when RING_OSC_CTRL_MINMAX_EN is defined.
//
// Result handshake: a result transfers on any clk edge where result_valid && result_ready;
// result_* stay stable while result_valid=1 and result_ready=0; result_ready is ignored otherwise.
module ring_osc_meas_ctrl
  import ring_osc_pkg::*;
#(
  parameter int TAP_W         = DEF_TAP_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sweep,
  input  logic [TAP_W-1:0] tap_sel,
  input  logic             abort,
  input  logic             osc_in,
  output logic             osc_en,
  output logic [TAP_W-1:0] tap,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [TAP_W-1:0] result_tap,
  output logic [CNT_W-1:0] result_count,
  output logic             result_ovf,
`ifdef RING_OSC_CTRL_MINMAX_EN
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
  output logic [TAP_W-1:0] min_tap,
  output logic [TAP_W-1:0] max_tap,
`endif
  output state_t           state_dbg
);

  localparam int PW = phase_cnt_width(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam logic [PW-1:0]    SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    WINDOW_LAST = PW'(WINDOW_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  logic             edge_pulse;
  logic             sweep_mode;
  logic [PW-1:0]    phase_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_ovf;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  osc_edge_sync u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .osc_in     (osc_in),
    .edge_pulse (edge_pulse)
  );

  // Saturating count: an edge arriving at full scale is lost and marks the window overflowed.
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = cnt_ovf;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) ovf_next = 1'b1;
      else                     cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      osc_en       <= 1'b0;
      tap          <= '0;
      sweep_mode   <= 1'b0;
      phase_cnt    <= '0;
      edge_cnt     <= '0;
      cnt_ovf      <= 1'b0;
      result_valid <= 1'b0;
      result_tap   <= '0;
      result_count <= '0;
      result_ovf   <= 1'b0;
    end else if (abort && state != IDLE) begin
      state        <= IDLE;
      osc_en       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            sweep_mode <= sweep;
            tap        <= sweep ? '0 : tap_sel;
            osc_en     <= 1'b1;
            phase_cnt  <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            phase_cnt <= '0;
            edge_cnt  <= '0;
            cnt_ovf   <= 1'b0;
            state     <= MEASURE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= cnt_next;
          cnt_ovf  <= ovf_next;
          if (phase_cnt == WINDOW_LAST) begin
            result_count <= cnt_next;
            result_ovf   <= ovf_next;
            result_tap   <= tap;
            result_valid <= 1'b1;
            state        <= REPORT;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (sweep_mode && tap != TAP_LAST) begin
              tap       <= tap + TAP_W'(1);
              phase_cnt <= '0;
              state     <= SETTLE;
            end else begin
              osc_en <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef RING_OSC_CTRL_MINMAX_EN
  logic first_result;
  logic xfer;

  assign xfer = (state == REPORT) && result_ready && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_result <= 1'b0;
      min_count    <= '0;
      max_count    <= '0;
      min_tap      <= '0;
      max_tap      <= '0;
    end else if (state == IDLE && start && !abort) begin
      first_result <= 1'b1;
    end else if (xfer) begin
      first_result <= 1'b0;
      // Strict compares so that ties keep the earlier tap.
      if (first_result || result_count < min_count) begin
        min_count <= result_count;
        min_tap   <= result_tap;
      end
      if (first_result || result_count > max_count) begin
        max_count <= result_count;
        max_tap   <= result_tap;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Self-checking bench for ring_osc_meas_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honours RING_OSC_CTRL_MINMAX_EN when defined.
module tb_ring_osc_meas_ctrl;
  import ring_osc_pkg::*;

  localparam int TAP_W  = 3;
  localparam int CNT_W  = 4;
  localparam int WIN    = 64;
  localparam int SET    = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int TMAX   = (1 << TAP_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sweep;
  logic [TAP_W-1:0] tap_sel;
  logic             abort;
  logic             osc_in;
  logic             osc_en;
  logic [TAP_W-1:0] tap;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [TAP_W-1:0] result_tap;
  logic [CNT_W-1:0] result_count;
  logic             result_ovf;
  state_t           state_dbg;
`ifdef RING_OSC_CTRL_MINMAX_EN
  logic [CNT_W-1:0] min_count;
  logic [CNT_W-1:0] max_count;
  logic [TAP_W-1:0] min_tap;
  logic [TAP_W-1:0] max_tap;
`endif

  ring_osc_meas_ctrl #(
    .TAP_W         (TAP_W),
    .CNT_W         (CNT_W),
    .WINDOW_CYCLES (WIN),
    .SETTLE_CYCLES (SET)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sweep        (sweep),
    .tap_sel      (tap_sel),
    .abort        (abort),
    .osc_in       (osc_in),
    .osc_en       (osc_en),
    .tap          (tap),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_tap   (result_tap),
    .result_count (result_count),
    .result_ovf   (result_ovf),
`ifdef RING_OSC_CTRL_MINMAX_EN
    .min_count    (min_count),
    .max_count    (max_count),
    .min_tap      (min_tap),
    .max_tap      (max_tap),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset / oscillator ----------------
  int osc_period = 8;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transitions land at 2 or 7 mod 10, never on a clk edge.
  initial begin
    osc_in = 1'b0;
    #2;
    forever begin
      #(osc_period * 5);
      osc_in = ~osc_in;
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_range(input string name, input longint act,
                                      input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  bit              m_busy, m_osc_en, m_valid, m_sweep;
  int              m_tap, m_rtap, m_elapsed, m_edges;
  int              m_lo, m_hi, m_ovf_req;  // m_ovf_req: 0, 1, or 2 = either
  bit              osc_prev_s;
  int              mm_min_lo, mm_min_hi, mm_max_lo, mm_max_hi;
  bit              mm_first, mm_check;
  logic [TAP_W-1:0] exp_q[$];

  initial begin
    bit rise;
    forever begin
      @(posedge clk);
      cyc++;
      rise = osc_in && !osc_prev_s;
      osc_prev_s = osc_in;
      if (!rst_n) begin
        m_busy = 0; m_osc_en = 0; m_valid = 0; m_tap = 0; m_rtap = 0;
        m_lo = 0; m_hi = 0; m_ovf_req = 0;
        mm_min_lo = 0; mm_min_hi = 0; mm_max_lo = 0; mm_max_hi = 0;
        mm_check = 1; mm_first = 0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1; m_osc_en = 1; m_sweep = sweep;
          m_tap = sweep ? 0 : int'(tap_sel);
          m_elapsed = 0; m_edges = 0;
          mm_first = 1; mm_check = 0;
        end
      end else if (abort) begin
        m_busy = 0; m_osc_en = 0;
        if (m_valid) void'(exp_q.pop_back());
        m_valid = 0;
      end else if (m_valid) begin
        if (result_ready) begin
          m_valid = 0;
          if (mm_first) begin
            mm_min_lo = m_lo; mm_min_hi = m_hi; mm_max_lo = m_lo; mm_max_hi = m_hi;
            mm_first = 0;
          end else begin
            if (m_lo < mm_min_lo) mm_min_lo = m_lo;
            if (m_hi < mm_min_hi) mm_min_hi = m_hi;
            if (m_lo > mm_max_lo) mm_max_lo = m_lo;
            if (m_hi > mm_max_hi) mm_max_hi = m_hi;
          end
          if (m_sweep && m_tap < TMAX) begin
            m_tap++; m_elapsed = 0; m_edges = 0;
          end else begin
            m_busy = 0; m_osc_en = 0; mm_check = 1;
          end
        end
      end else begin
        // Window covers cycles SET+1 .. SET+WIN after start / tap change.
        m_elapsed++;
        if (m_elapsed > SET && rise) m_edges++;
        if (m_elapsed == SET + WIN) begin
          m_valid = 1;
          m_rtap  = m_tap;
          m_lo = (m_edges - 1 > CMAX) ? CMAX : ((m_edges > 0) ? m_edges - 1 : 0);
          m_hi = (m_edges + 1 > CMAX) ? CMAX : m_edges + 1;
          m_ovf_req = (m_edges >= CMAX + 2) ? 1 : ((m_edges <= CMAX - 1) ? 0 : 2);
          exp_q.push_back(TAP_W'(m_tap));
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int xfer_log[$];

  initial begin
    logic [TAP_W-1:0] exp_tap;
    forever begin
      @(negedge clk);
      check("osc_en", osc_en, m_osc_en);
      check("busy", busy, m_busy);
      check("state_idle", state_dbg == IDLE, !m_busy);
      check("tap", tap, m_tap);
      check("result_valid", result_valid, m_valid);
      check("result_tap", result_tap, m_rtap);
      check_range("result_count", result_count, m_lo, m_hi);
      if (m_ovf_req != 2) check("result_ovf", result_ovf, m_ovf_req);
`ifdef RING_OSC_CTRL_MINMAX_EN
      if (mm_check) begin
        check_range("min_count", min_count, mm_min_lo, mm_min_hi);
        check_range("max_count", max_count, mm_max_lo, mm_max_hi);
      end
`endif
      if (result_valid && result_ready) begin
        xfer_log.push_back(int'(result_tap));
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          exp_tap = exp_q.pop_front();
          check("xfer_tap", result_tap, exp_tap);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input bit sw, input int tsel);
    start = 1'b1; sweep = sw; tap_sel = TAP_W'(tsel);
    tick();
    start = 1'b0;
  endtask

  // Counts ticks (including the start tick already taken) until result_valid.
  task automatic wait_valid(input int bound, inout int n);
    while (!result_valid && n < bound) begin
      tick();
      n++;
    end
    if (!result_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; sweep = 1'b0; tap_sel = '0; abort = 1'b0; result_ready = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_count", result_count, 0);
    rst_n = 1'b1;
    tick();

    // Single tap 5, period 8: latency 1+SET+WIN, ~8 edges.
    osc_period = 8; result_ready = 1'b1;
    start = 1'b1; sweep = 1'b0; tap_sel = 3'd5;
    tick();
    start = 1'b0;
    check("t1_tap", tap, 5);
    check("t1_osc_en", osc_en, 1);
    n = 1;
    wait_valid(200, n);
    check("t1_latency", n, 69);
    check("t1_result_tap", result_tap, 5);
    check_range("t1_count", result_count, 7, 9);
    check("t1_ovf", result_ovf, 0);
    wait_idle(10);

    // Full sweep with ready held high.
    xfer_log.delete();
    issue_start(1'b1, 6);
    wait_idle(1000);
    check("t2_xfers", xfer_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < xfer_log.size()) check("t2_order", xfer_log[i], i);
    check("t2_osc_en", osc_en, 0);
    check("t2_busy", busy, 0);

    // Saturation: period 4 gives 16 edges into a 4-bit counter.
    osc_period = 4;
    issue_start(1'b0, 2);
    n = 1;
    wait_valid(200, n);
    check("t3_count", result_count, 15);
    check("t3_ovf", result_ovf, 1);
    wait_idle(10);

    // Backpressure: hold ready low for 20 cycles in REPORT.
    osc_period = 8; result_ready = 1'b0; xfer_log.delete();
    issue_start(1'b0, 1);
    n = 1;
    wait_valid(200, n);
    repeat (20) tick();
    check("t4_valid_held", result_valid, 1);
    check("t4_tap_held", result_tap, 1);
    check_range("t4_count_held", result_count, 7, 9);
    result_ready = 1'b1;
    tick();
    check("t4_valid_drop", result_valid, 0);
    repeat (3) tick();
    check("t4_one_xfer", xfer_log.size(), 1);

    // Abort mid-MEASURE of sweep tap 3; a start while busy is ignored.
    xfer_log.delete();
    issue_start(1'b1, 0);
    n = 0;
    while (!(busy && tap == 3) && n < 1000) begin tick(); n++; end
    check("t5_reach_tap3", tap, 3);
    repeat (SET + 5) tick();
    issue_start(1'b0, 6);
    repeat (3) tick();
    check("t5_start_ignored", tap, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_osc_en", osc_en, 0);
    check("t5_valid", result_valid, 0);
    repeat (SET + WIN + 4) tick();
    check("t5_no_result", result_valid, 0);
    check("t5_xfers", xfer_log.size(), 3);

    // Reset pulse during SETTLE, then a fresh measurement.
    issue_start(1'b0, 4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_osc_en", osc_en, 0);
    check("t6_tap", tap, 0);
    check("t6_count", result_count, 0);
    check("t6_result_tap", result_tap, 0);
    issue_start(1'b0, 6);
    n = 1;
    wait_valid(200, n);
    check("t6_latency", n, 69);
    check("t6_result_tap2", result_tap, 6);
    check_range("t6_count2", result_count, 7, 9);
    wait_idle(10);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      result_ready = ($urandom_range(0, 3) != 0);
      start = 1'b0; abort = 1'b0;
      if (!busy && $urandom_range(0, 9) == 0) begin
        osc_period = $urandom_range(5, 12);
        start = 1'b1;
        sweep = ($urandom_range(0, 3) == 0);
        tap_sel = TAP_W'($urandom_range(0, TMAX));
        if ($urandom_range(0, 15) == 0) abort = 1'b1;
      end else if (busy && $urandom_range(0, 199) == 0) begin
        abort = 1'b1;
      end else if (busy && $urandom_range(0, 19) == 0) begin
        start = 1'b1;
        tap_sel = TAP_W'($urandom_range(0, TMAX));
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; result_ready = 1'b1;
    wait_idle(1500);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
